// File: rtl/wb_scoreboard.sv
// wb_scoreboard: MEM/WB pipeline register, writeback mux and per-register pending-write scoreboard.
module wb_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_regwrite,
  input  logic [4:0]  issue_dest,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        stall,
  input  logic        mem_valid,
  input  logic        mem_kill,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic        mem_link,
  input  logic [4:0]  mem_writereg,
  input  logic [31:0] mem_aluresult,
  input  logic [31:0] mem_readdata,
  input  logic [31:0] mem_pc8,
  output logic        RegWrite,
  output logic [4:0]  writereg,
  output logic [31:0] writedata,
  output logic        sb_err
);
  logic        r_wb_valid, r_wb_regwrite, r_wb_memtoreg, r_wb_link;
  logic [4:0]  r_wb_writereg;
  logic [31:0] r_wb_aluresult, r_wb_readdata, r_wb_pc8;
  logic [1:0]  r_cnt [32];
  logic [1:0]  w_cnt_nxt [32];
  logic        r_sb_err, w_err;
  logic [31:0] w_inc, w_dec_wb, w_dec_kill;
  logic [3:0]  w_sum;
  logic        w_busy_rs, w_busy_rt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_link      <= 1'b0;
      r_wb_writereg  <= '0;
      r_wb_aluresult <= '0;
      r_wb_readdata  <= '0;
      r_wb_pc8       <= '0;
    end else begin
      r_wb_valid     <= mem_valid & ~mem_kill;
      r_wb_regwrite  <= mem_regwrite;
      r_wb_memtoreg  <= mem_memtoreg;
      r_wb_link      <= mem_link;
      r_wb_writereg  <= mem_writereg;
      r_wb_aluresult <= mem_aluresult;
      r_wb_readdata  <= mem_readdata;
      r_wb_pc8       <= mem_pc8;
    end
  // Link always targets r31, so a zero destination field must not suppress it.
  assign RegWrite  = r_wb_valid & r_wb_regwrite & (r_wb_link | (r_wb_writereg != 5'd0));
  assign writereg  = r_wb_link ? 5'd31 : r_wb_writereg;
  assign writedata = r_wb_link ? r_wb_pc8 : r_wb_memtoreg ? r_wb_readdata : r_wb_aluresult;
  assign sb_err    = r_sb_err;
  // A claim retiring this cycle is visible to ID through the falling-edge register-file write.
  assign w_busy_rs = (rs != 5'd0) & (r_cnt[rs] != 2'd0) & ~(RegWrite & (writereg == rs) & (r_cnt[rs] == 2'd1));
  assign w_busy_rt = (rt != 5'd0) & (r_cnt[rt] != 2'd0) & ~(RegWrite & (writereg == rt) & (r_cnt[rt] == 2'd1));
  assign stall     = issue_valid & (w_busy_rs | w_busy_rt);
  assign w_inc      = (issue_valid & issue_regwrite & ~stall) ? (32'd1 << issue_dest) : 32'd0;
  assign w_dec_wb   = RegWrite ? (32'd1 << writereg) : 32'd0;
  assign w_dec_kill = (mem_valid & mem_kill & mem_regwrite) ? (32'd1 << mem_writereg) : 32'd0;
  // Sum range is -2..4; bit 2 set means under- or overflow, so the counter holds.
  always_comb begin
    w_err = 1'b0;
    w_sum = 4'd0;
    w_cnt_nxt = r_cnt;
    for (int i = 1; i < 32; i++) begin
      w_sum = {2'b0, r_cnt[i]} + {3'b0, w_inc[i]} - {3'b0, w_dec_wb[i]} - {3'b0, w_dec_kill[i]};
      w_cnt_nxt[i] = w_sum[2] ? r_cnt[i] : w_sum[1:0];
      w_err = w_err | w_sum[2];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sb_err <= 1'b0;
      for (int i = 0; i < 32; i++) r_cnt[i] <= 2'd0;
    end else begin
      r_sb_err <= r_sb_err | w_err;
      for (int i = 1; i < 32; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
endmodule
